// File: rtl/res_pkg.sv
// Shared constants and types for the adder stimulus driver and the result collector.
package res_pkg;

   localparam int RES_WIDTH_DEF = 8;
   localparam int NUM_DEF       = 100;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DONE
   } state_t;

   // Counter must be able to hold NUM itself, not only NUM-1.
   function automatic int cnt_width(input int num);
      return $clog2(num + 1);
   endfunction

endpackage

// File: rtl/res_collector_vld_delay.sv
// LAT-deep strobe delay line; LAT=0 degenerates to a wire.
module vld_delay #(
   parameter int LAT = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic vld_i,
   output logic vld_o
);

   generate
      if (LAT == 0) begin : g_bypass
         logic unused_ok;
         assign unused_ok = &{1'b0, clk_i, reset_i};
         assign vld_o     = vld_i;
      end else begin : g_shift
         logic [LAT:0] tap;
         assign tap[0] = vld_i;

         for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            logic stage_q;
            logic stage_d;

            always_comb begin
               stage_d = tap[gi];
            end

            always_ff @(posedge clk_i) begin
               if (reset_i) begin
                  stage_q <= 1'b0;
               end else begin
                  stage_q <= stage_d;
               end
            end

            assign tap[gi+1] = stage_q;
         end

         assign vld_o = tap[LAT];
      end
   endgenerate

endmodule

// File: rtl/res_collector.sv
// Captures NUM aligned adder results LSB-first into one package word and
// holds it until the consumer acknowledges.
module res_collector
   import res_pkg::*;
#(
   parameter  int RES_WIDTH = RES_WIDTH_DEF,
   parameter  int NUM       = NUM_DEF,
   parameter  int LAT       = 1,
   localparam int PKG_WIDTH = NUM * RES_WIDTH,
   localparam int CNT_W     = cnt_width(NUM)
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 beat_valid_i,
   input  logic [RES_WIDTH-1:0] res_i,
   input  logic                 ack_i,
   output logic [PKG_WIDTH-1:0] pkg_o,
   output logic                 pkg_valid_o,
   output logic                 busy_o,
   output logic [CNT_W-1:0]     count_o,
   output logic                 overflow_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM - 1);

   logic vld_d;

   vld_delay #(
      .LAT (LAT)
   ) u_vld_delay (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .vld_i   (beat_valid_i),
      .vld_o   (vld_d)
   );

   state_t                 state_q,     state_d;
   logic [PKG_WIDTH-1:0]   pkg_q,       pkg_d;
   logic [CNT_W-1:0]       count_q,     count_d;
   logic                   pkg_valid_q, pkg_valid_d;
   logic                   busy_q,      busy_d;
   logic                   overflow_q,  overflow_d;

   always_comb begin
      state_d    = state_q;
      pkg_d      = pkg_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE: begin
            if (vld_d) begin
               overflow_d = 1'b1;
            end
            if (start_i) begin
               state_d = COLLECT;
               count_d = '0;
               pkg_d   = '0;
            end
         end

         COLLECT: begin
            if (vld_d) begin
               pkg_d[int'(count_q) * RES_WIDTH +: RES_WIDTH] = res_i;
               count_d = count_q + CNT_W'(1);
               if (count_q == LAST_CNT) begin
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            if (vld_d) begin
               overflow_d = 1'b1;
            end
            // start_i only counts once the held package has been released.
            if (ack_i) begin
               if (start_i) begin
                  state_d = COLLECT;
                  count_d = '0;
                  pkg_d   = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      pkg_valid_d = (state_d == DONE);
      busy_d      = (state_d == COLLECT);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         pkg_q       <= '0;
         count_q     <= '0;
         pkg_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkg_q       <= pkg_d;
         count_q     <= count_d;
         pkg_valid_q <= pkg_valid_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
      end
   end

   assign pkg_o       = pkg_q;
   assign pkg_valid_o = pkg_valid_q;
   assign busy_o      = busy_q;
   assign count_o     = count_q;
   assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_res_collector.sv
// Directed bench for res_collector: instance 0 has LAT=1, instance 1 LAT=0, instance 2 LAT=3.
module tb_res_collector;

   localparam int W  = 8;
   localparam int N  = 100;
   localparam int PW = N * W;
   localparam int CW = 7;

   logic clk = 1'b0;
   logic reset;

   logic          start_s [3];
   logic          beat_s  [3];
   logic          ack_s   [3];
   logic [W-1:0]  res_s   [3];
   logic [PW-1:0] pkg_s   [3];
   logic          valid_s [3];
   logic          busy_s  [3];
   logic          ovf_s   [3];
   logic [CW-1:0] cnt_s   [3];

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int L = (gi == 0) ? 1 : ((gi == 1) ? 0 : 3);
         res_collector #(
            .RES_WIDTH (W),
            .NUM       (N),
            .LAT       (L)
         ) dut (
            .clk_i        (clk),
            .reset_i      (reset),
            .start_i      (start_s[gi]),
            .beat_valid_i (beat_s[gi]),
            .res_i        (res_s[gi]),
            .ack_i        (ack_s[gi]),
            .pkg_o        (pkg_s[gi]),
            .pkg_valid_o  (valid_s[gi]),
            .busy_o       (busy_s[gi]),
            .count_o      (cnt_s[gi]),
            .overflow_o   (ovf_s[gi])
         );
      end
   endgenerate

   function automatic int lat_of(input int inst);
      return (inst == 0) ? 1 : ((inst == 1) ? 0 : 3);
   endfunction

   function automatic logic [PW-1:0] ramp_pkg();
      logic [PW-1:0] p;
      p = '0;
      for (int k = 0; k < N; k++) p[k*W +: W] = W'(k);
      return p;
   endfunction

   function automatic logic [PW-1:0] const_pkg(input logic [W-1:0] v);
      logic [PW-1:0] p;
      for (int k = 0; k < N; k++) p[k*W +: W] = v;
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int inst);
      start_s[inst] = 1'b1;
      tick();
      start_s[inst] = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   // Launch n beats every (gap+1) cycles; results follow their launch by the
   // instance latency. Off-beat cycles carry 0x5A so stray sampling shows up.
   task automatic drive_pkg(input int inst, input int n, input int gap,
                            input bit use_const, input logic [W-1:0] cval,
                            output bit early_valid);
      int lat;
      int step;
      int last;
      lat  = lat_of(inst);
      step = gap + 1;
      last = (n - 1) * step + lat;
      early_valid = 1'b0;
      for (int t = 0; t <= last; t++) begin
         beat_s[inst] = ((t % step) == 0) && ((t / step) < n);
         if (t >= lat && ((t - lat) % step) == 0 && ((t - lat) / step) < n)
            res_s[inst] = use_const ? cval : W'((t - lat) / step);
         else
            res_s[inst] = 8'h5A;
         if (valid_s[inst]) early_valid = 1'b1;
         tick();
      end
      beat_s[inst] = 1'b0;
      res_s[inst]  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if ({valid_s[i], busy_s[i], ovf_s[i], cnt_s[i]} !== 10'd0) begin
            tests_failed++;
            $display("FAIL reset_flags[%0d]: got valid=%b busy=%b ovf=%b cnt=%0d, expected all 0",
                     i, valid_s[i], busy_s[i], ovf_s[i], cnt_s[i]);
         end
         tests_run++;
         if (pkg_s[i] !== '0) begin
            tests_failed++;
            $display("FAIL reset_pkg[%0d]: got nonzero pkg (low byte %h), expected 0", i, pkg_s[i][7:0]);
         end
      end
      $display("[TB] test_reset: reset applied to all instances");
   endtask

   task automatic test_basic();
      bit ev;
      do_start(0);
      tests_run++;
      if (busy_s[0] !== 1'b1 || cnt_s[0] !== 7'd0) begin
         tests_failed++;
         $display("FAIL basic_start: got busy=%b cnt=%0d, expected busy=1 cnt=0", busy_s[0], cnt_s[0]);
      end
      drive_pkg(0, N, 0, 1'b0, 8'h00, ev);
      tests_run++;
      if (ev !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_early_valid: got pkg_valid before last sample, expected 0");
      end
      tests_run++;
      if (valid_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_valid: got valid=%b busy=%b, expected valid=1 busy=0", valid_s[0], busy_s[0]);
      end
      tests_run++;
      if (pkg_s[0][7:0] !== 8'h00 || pkg_s[0][799:792] !== 8'h63) begin
         tests_failed++;
         $display("FAIL basic_ends: got slot0=%h slot99=%h, expected 00 and 63", pkg_s[0][7:0], pkg_s[0][799:792]);
      end
      tests_run++;
      if (pkg_s[0] !== ramp_pkg()) begin
         tests_failed++;
         $display("FAIL basic_pkg: got slot50=%h, expected ramp 0..99 (slot50=32)", pkg_s[0][50*W +: W]);
      end
      tests_run++;
      if (cnt_s[0] !== 7'd100 || ovf_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_cnt_ovf: got cnt=%0d ovf=%b, expected cnt=100 ovf=0", cnt_s[0], ovf_s[0]);
      end
      $display("[TB] test_basic: ramp package of %0d beats captured", N);
   endtask

   task automatic test_extra_beat();
      beat_s[0] = 1'b1;
      res_s[0]  = 8'h5A;
      tick();
      beat_s[0] = 1'b0;
      res_s[0]  = 8'hFF;
      tick();
      res_s[0]  = '0;
      tests_run++;
      if (pkg_s[0] !== ramp_pkg() || cnt_s[0] !== 7'd100 || valid_s[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL extra_hold: got cnt=%0d valid=%b slot99=%h, expected 100/1/63",
                  cnt_s[0], valid_s[0], pkg_s[0][799:792]);
      end
      tests_run++;
      if (ovf_s[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL extra_ovf: got ovf=%b, expected 1", ovf_s[0]);
      end
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      tests_run++;
      if (valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || ovf_s[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL extra_ack: got valid=%b busy=%b ovf=%b, expected 0/0/1", valid_s[0], busy_s[0], ovf_s[0]);
      end
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      tests_run++;
      if (valid_s[0] !== 1'b0 || busy_s[0] !== 1'b0 || ovf_s[0] !== 1'b1) begin
         tests_failed++;
         $display("FAIL idle_ack: got valid=%b busy=%b ovf=%b, expected 0/0/1", valid_s[0], busy_s[0], ovf_s[0]);
      end
      $display("[TB] test_extra_beat: 101st beat dropped, overflow sticky");
   endtask

   task automatic test_reset_mid();
      bit ev;
      pulse_reset();
      tests_run++;
      if (ovf_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_clears_ovf: got ovf=%b, expected 0", ovf_s[0]);
      end
      beat_s[0] = 1'b1;
      tick();
      beat_s[0] = 1'b0;
      tick();
      tests_run++;
      if (ovf_s[0] !== 1'b1 || busy_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL idle_beat_ovf: got ovf=%b busy=%b, expected 1/0", ovf_s[0], busy_s[0]);
      end
      pulse_reset();
      do_start(0);
      drive_pkg(0, 40, 0, 1'b0, 8'h00, ev);
      tests_run++;
      if (cnt_s[0] !== 7'd40 || busy_s[0] !== 1'b1 || valid_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL partial_state: got cnt=%0d busy=%b valid=%b, expected 40/1/0", cnt_s[0], busy_s[0], valid_s[0]);
      end
      tests_run++;
      if (pkg_s[0][39*W +: W] !== 8'd39 || pkg_s[0][40*W +: W] !== 8'd0) begin
         tests_failed++;
         $display("FAIL partial_slots: got slot39=%h slot40=%h, expected 27 and 00",
                  pkg_s[0][39*W +: W], pkg_s[0][40*W +: W]);
      end
      pulse_reset();
      tests_run++;
      if (cnt_s[0] !== 7'd0 || busy_s[0] !== 1'b0 || pkg_s[0] !== '0 || valid_s[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset: got cnt=%0d busy=%b valid=%b pkg_nonzero=%b, expected 0/0/0/0",
                  cnt_s[0], busy_s[0], valid_s[0], |pkg_s[0]);
      end
      do_start(0);
      drive_pkg(0, N, 0, 1'b0, 8'h00, ev);
      tests_run++;
      if (ev !== 1'b0 || valid_s[0] !== 1'b1 || cnt_s[0] !== 7'd100 || pkg_s[0] !== ramp_pkg()) begin
         tests_failed++;
         $display("FAIL rerun_after_reset: got early=%b valid=%b cnt=%0d slot99=%h, expected 0/1/100/63",
                  ev, valid_s[0], cnt_s[0], pkg_s[0][799:792]);
      end
      $display("[TB] test_reset_mid: partial package discarded, fresh package captured");
   endtask

   task automatic test_ack_start();
      do_start(0);
      tests_run++;
      if (valid_s[0] !== 1'b1 || busy_s[0] !== 1'b0 || cnt_s[0] !== 7'd100 || pkg_s[0] !== ramp_pkg()) begin
         tests_failed++;
         $display("FAIL done_start_ignored: got valid=%b busy=%b cnt=%0d, expected 1/0/100 with package held",
                  valid_s[0], busy_s[0], cnt_s[0]);
      end
      ack_s[0]   = 1'b1;
      start_s[0] = 1'b1;
      tick();
      ack_s[0]   = 1'b0;
      start_s[0] = 1'b0;
      tests_run++;
      if (busy_s[0] !== 1'b1 || valid_s[0] !== 1'b0 || cnt_s[0] !== 7'd0 || pkg_s[0] !== '0) begin
         tests_failed++;
         $display("FAIL ack_start: got busy=%b valid=%b cnt=%0d pkg_nonzero=%b, expected 1/0/0/0",
                  busy_s[0], valid_s[0], cnt_s[0], |pkg_s[0]);
      end
      $display("[TB] test_ack_start: ack with start re-arms directly");
   endtask

   task automatic test_gaps();
      bit ev;
      drive_pkg(0, N, 1, 1'b1, 8'hA5, ev);
      tests_run++;
      if (ev !== 1'b0 || valid_s[0] !== 1'b1 || cnt_s[0] !== 7'd100) begin
         tests_failed++;
         $display("FAIL gaps_done: got early=%b valid=%b cnt=%0d, expected 0/1/100", ev, valid_s[0], cnt_s[0]);
      end
      tests_run++;
      if (pkg_s[0] !== const_pkg(8'hA5)) begin
         tests_failed++;
         $display("FAIL gaps_pkg: got slot0=%h slot99=%h, expected all A5", pkg_s[0][7:0], pkg_s[0][799:792]);
      end
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      $display("[TB] test_gaps: alternate-cycle beats packed as A5");
   endtask

   task automatic test_lat();
      bit ev;
      for (int inst = 1; inst < 3; inst++) begin
         do_start(inst);
         drive_pkg(inst, N, 0, 1'b0, 8'h00, ev);
         tests_run++;
         if (ev !== 1'b0 || valid_s[inst] !== 1'b1 || cnt_s[inst] !== 7'd100) begin
            tests_failed++;
            $display("FAIL lat%0d_done: got early=%b valid=%b cnt=%0d, expected 0/1/100",
                     lat_of(inst), ev, valid_s[inst], cnt_s[inst]);
         end
         tests_run++;
         if (pkg_s[inst] !== ramp_pkg() || ovf_s[inst] !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat%0d_pkg: got slot0=%h slot99=%h ovf=%b, expected 00/63/0",
                     lat_of(inst), pkg_s[inst][7:0], pkg_s[inst][799:792], ovf_s[inst]);
         end
         $display("[TB] test_lat: LAT=%0d ramp package captured", lat_of(inst));
      end
   endtask

   initial begin
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         start_s[i] = 1'b0;
         beat_s[i]  = 1'b0;
         ack_s[i]   = 1'b0;
         res_s[i]   = '0;
      end
      tick();
      test_reset();
      test_basic();
      test_extra_beat();
      test_reset_mid();
      test_ack_start();
      test_gaps();
      test_lat();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/res_collector.md
Name: res_collector

Overview:
- Downstream capture stage for the adder stimulus driver.
- Watches the adder result bus, aligns it to the driver's per-beat launch strobe through a fixed pipeline delay, and packs NUM consecutive results LSB-first into one wide package word.
- The software side (cocotb) reads and checks the whole package in a single access, mirroring how the driver consumes a packed stimulus word.

Parameters:
- RES_WIDTH, 8, width of one adder result.
- NUM, 100, results per package.
- LAT, 1, cycles from the launch strobe to a valid result on res_i; 0 to 7 allowed, 0 means same-cycle.
- PKG_WIDTH, NUM*RES_WIDTH (800), package width; derived, not to be overridden.
- CNT_W, $clog2(NUM+1), width of the beat counter.

Ports:
- clk_i  in  1  system clock, all logic on posedge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse that arms collection of one package.
- beat_valid_i  in  1  high in the cycle the driver launches an operand pair.
- res_i  in  RES_WIDTH  adder result bus.
- ack_i  in  1  consumer has read pkg_o; releases the package.
- pkg_o  out  PKG_WIDTH  packed results; beat k occupies bits [k*RES_WIDTH +: RES_WIDTH].
- pkg_valid_o  out  1  package complete and stable.
- busy_o  out  1  high while in COLLECT.
- count_o  out  CNT_W  beats captured in the current package.
- overflow_o  out  1  sticky: an aligned beat arrived while not collecting.

Behaviour:
- Reset (synchronous, reset_i high at a posedge):
  - All outputs go to 0.
  - State goes to IDLE.
  - Delay line is flushed to 0.
  - Reset wins over every other input in the same cycle, including mid-COLLECT; a partial package is discarded.
- Alignment:
  - beat_valid_i passes through a LAT-stage shift register to give vld_d.
  - res_i is sampled in the cycle vld_d=1.
  - With LAT=0, vld_d = beat_valid_i combinationally.
- FSM has three states: IDLE, COLLECT, DONE.
- IDLE:
  - start_i -> COLLECT next cycle; count_o cleared to 0, pkg_o cleared to 0.
  - vld_d=1 -> sample dropped, overflow_o set.
- COLLECT (busy_o=1):
  - Each cycle with vld_d=1, write res_i into slot count_o, then count_o+1.
  - start_i is ignored.
  - On the capture that brings count_o to NUM -> DONE; pkg_valid_o rises the next cycle, i.e. registered in the same edge as the final write.
  - Latency: last res_i sampled at edge t gives pkg_valid_o=1 after edge t.
- DONE (pkg_valid_o=1):
  - pkg_o and count_o (=NUM) hold.
  - vld_d=1 -> dropped, overflow_o set.
  - ack_i -> IDLE, pkg_valid_o cleared.
  - ack_i and start_i in the same cycle -> COLLECT directly; count_o and pkg_o cleared, pkg_valid_o cleared.
  - start_i without ack_i is ignored; the package is never overwritten before acknowledgement.
- ack_i outside DONE has no effect.
- overflow_o clears only on reset.
- Slots not yet written read 0; partial packages are never flagged valid.
- count_o never exceeds NUM; there is no wrap-around.

Decomposition:
- Shared package res_pkg holds:
  - RES_WIDTH and NUM defaults.
  - The state enum typedef {IDLE, COLLECT, DONE}.
  - A function computing CNT_W.
- The driver shares the same NUM/width constants from res_pkg.
- One sub-module, vld_delay:
  - Parameterised LAT-deep shift register with clk_i/reset_i.
  - Generate-bypassed when LAT=0.
  - Reused later for other aligned monitors.
- Slot write is an indexed part-select on a PKG_WIDTH register; no RAM.

Test Plan:
- Reset, then start_i, then 100 beats with res_i = k (k=0..99), LAT=1 -> pkg_valid_o=1 exactly one cycle after the 100th aligned sample; pkg_o[7:0]=0x00, pkg_o[799:792]=0x63; count_o=100; overflow_o=0.
- Gaps: beat_valid_i high only on alternate cycles, res_i=0xA5 constant -> all 100 slots = 0xA5; completion after about 200 cycles; no samples taken on gap cycles.
- Extra beat after completion (101st beat, res_i=0xFF) -> pkg_o unchanged, overflow_o=1 and stays 1 after ack_i; beat before any start_i also sets overflow_o.
- reset_i asserted after 40 captured beats -> next cycle count_o=0, busy_o=0, pkg_o=0; a fresh start_i plus 100 beats completes normally.
- In DONE, hold ack_i and start_i high together for one cycle -> busy_o=1, pkg_valid_o=0, count_o=0 next cycle. start_i alone in DONE -> no change.
- Re-run the first case with LAT=0 and LAT=3 (beat_valid_i held 3 cycles ahead of res_i) -> identical pkg_o contents.
